// File: rtl/mont_mul_arb_pkg.sv
// Shared types and constants for the Montgomery multiplier arbiter.
// State encoding, default operand width and the requester-id width helper.
package mont_mul_arb_pkg;

  localparam int MM_WIDTH = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mont_mul_arbiter_rr_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping.
// Purely combinational; ptr must be below N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_valid
);

  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;

  // rotate so that bit 0 is the requester under the pointer
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};

  assign grant = (sum >= (IW + 1)'(N))
               ? IW'(sum - (IW + 1)'(N))
               : sum[IW-1:0];

  assign any_valid = |req;

endmodule

// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier among requesters.
// Define MM_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_err.
module mont_mul_arbiter
  import mont_mul_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = MM_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW            = id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [WIDTH-1:0]         mm_a,
  output logic [WIDTH-1:0]         mm_b,
  output logic                     mm_start,
  input  logic                     mm_done,
  input  logic [WIDTH-1:0]         mm_out
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mont_mul_arbiter: unsupported parameters");
  end

  state_t state, state_n;
  logic [IW-1:0] ptr, grant, ptr_n;
  logic any_valid, take, expire;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // grant only from a settled IDLE, never while reset is held
  assign take = (state == IDLE) && any_valid && !rst;

  assign ptr_n = (grant == IW'(NUM_REQ - 1))
               ? '0 : grant + IW'(1);

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant] = 1'b1;
  end

  assign mm_start  = (state == ISSUE);
  assign rsp_valid = (state == RESP);

`ifdef MM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign expire = (state == WAIT) && !mm_done
               && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      if (take) rsp_err <= 1'b0;
      else if (state == WAIT && mm_done) rsp_err <= 1'b0;
      else if (expire) rsp_err <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (take) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (mm_done || expire) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        mm_a   <= req_a[grant*WIDTH +: WIDTH];
        mm_b   <= req_b[grant*WIDTH +: WIDTH];
        rsp_id <= grant;
        ptr    <= ptr_n;
      end
      if (state == WAIT && mm_done) rsp_data <= mm_out;
      else if (expire) rsp_data <= '0;
    end
  end

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Bench for mont_mul_arbiter: directed steps plus random traffic
// against a queue-based round-robin reference and a fixed-latency core stub.
module tb_mont_mul_arbiter;

  localparam int N = 4;
  localparam int W = 255;
  localparam int L = 8;
`ifdef MM_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data, mm_a, mm_b, mm_out;
  logic mm_start, mm_done;

  mont_mul_arbiter #(
    .NUM_REQ        (N),
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_start  (mm_start),
    .mm_done   (mm_done),
    .mm_out    (mm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core stub: done exactly L cycles after the start cycle
  logic core_en, stray;
  int stub_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stub_cnt <= 0;
    else if (mm_start) stub_cnt <= 1;
    else if (stub_cnt == L) stub_cnt <= 0;
    else if (stub_cnt != 0) stub_cnt <= stub_cnt + 1;
  end
  assign mm_done = (core_en && stub_cnt == L) || stray;
  assign mm_out  = mm_a + mm_b;

  typedef struct {
    int id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic err;
    int acc;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int grant_log[$];
  logic [W-1:0] data_log[$];

  int checks, failures, cyc, ptr_m;
  int rem[N];
  logic [W-1:0] na[N], nb[N];
  logic [N-1:0] last_hs;
  logic last_start, last_rv, prev_rv;
  logic rnd_mode, to_mode;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r[W-1:0];
  endfunction

  // reference rule: first valid index at or after the pointer
  function automatic int pick(input logic [N-1:0] v,
                              input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int n);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
    rem[i] = n;
  endtask

  task automatic reset_model();
    exp_q.delete();
    ptr_m = 0;
    prev_rv = 1'b0;
  endtask

  task automatic tick();
    logic [N-1:0] hs, one;
    int g;
    exp_t e;
    @(negedge clk);
    cyc++;
    hs = req_valid & req_ready;
    last_hs = hs;
    last_start = mm_start;
    last_rv = rsp_valid;
    chk("ready_onehot", $onehot0(req_ready), 1);
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mm_start", mm_start, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mm_a", mm_a, 0);
      chk("rst_mm_b", mm_b, 0);
    end else begin
      chk("rsp_spurious",
          rsp_valid && exp_q.size() == 0, 0);
      if (exp_q.size() == 0 && req_valid != 0) begin
        g = pick(req_valid, ptr_m);
        one = '0;
        one[g] = 1'b1;
        chk("grant", req_ready, one);
        if (hs != 0) begin
          e.id = g;
          e.a = req_a[g*W +: W];
          e.b = req_b[g*W +: W];
          e.data = to_mode ? '0 : e.a + e.b;
          e.err = to_mode;
          e.acc = cyc;
          e.lat = to_mode ? TO + 2 : L + 2;
          exp_q.push_back(e);
          grant_log.push_back(g);
          ptr_m = (g + 1) % N;
        end
      end else begin
        chk("ready_busy", req_ready, 0);
      end
      if (mm_start)
        chk("start_slot", exp_q.size() > 0
            && cyc == exp_q[0].acc + 1, 1);
      if (exp_q.size() > 0 && cyc > exp_q[0].acc) begin
        chk("mm_a", mm_a, exp_q[0].a);
        chk("mm_b", mm_b, exp_q[0].b);
      end
      if (rsp_valid && exp_q.size() > 0) begin
        if (!prev_rv)
          chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        chk("rsp_id", rsp_id, exp_q[0].id);
        chk("rsp_data", rsp_data, exp_q[0].data);
        chk("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_ready) begin
          data_log.push_back(rsp_data);
          void'(exp_q.pop_front());
          prev_rv = 1'b0;
        end else begin
          prev_rv = 1'b1;
        end
      end else begin
        prev_rv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          if (rem[i] > 1) begin
            rem[i]--;
            req_a[i*W +: W] = rnd_mode ? rnd() : na[i];
            req_b[i*W +: W] = rnd_mode ? rnd() : nb[i];
          end else begin
            rem[i] = 0;
            req_valid[i] = 1'b0;
          end
        end else if (rnd_mode) begin
          if (!req_valid[i] && $urandom_range(3) == 0)
            set_req(i, rnd(), rnd(), 1 + $urandom_range(2));
          else if (req_valid[i] && $urandom_range(15) == 0) begin
            req_valid[i] = 1'b0;
            rem[i] = 0;
          end
        end
      end
      if (rnd_mode) rsp_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_valid != 0)
           && n < budget) begin
      tick();
      n++;
    end
    chk("drain_bound",
        exp_q.size() == 0 && req_valid == 0, 1);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_hs == 0 && n < 50);
    chk("accept_bound", last_hs != 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rnd_mode = 1'b0;
    to_mode = 1'b0;
    core_en = 1'b1;
    stray = 1'b0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      na[i] = '0;
      nb[i] = '0;
    end
    reset_model();

    // reset with every requester asking
    req_valid = '1;
    rst = 1'b1;
    repeat (3) tick();
    req_valid = '0;
    rst = 1'b0;

    // single request from requester 2
    grant_log.delete();
    data_log.delete();
    set_req(2, 255'h101, 255'h10, 1);
    run_until_idle(60);
    chk("single_grants", grant_log.size(), 1);
    if (grant_log.size() == 1)
      chk("single_id", grant_log[0], 2);
    if (data_log.size() == 1)
      chk("single_data", data_log[0], 255'h111);

    // all four from reset, requester 0 returns
    rst = 1'b1;
    reset_model();
    tick();
    grant_log.delete();
    data_log.delete();
    for (int i = 0; i < N; i++)
      set_req(i, W'(i), 255'd1, (i == 0) ? 2 : 1);
    na[0] = 255'd10;
    nb[0] = 255'd5;
    rst = 1'b0;
    run_until_idle(120);
    chk("rr_count", grant_log.size(), 5);
    if (grant_log.size() == 5 && data_log.size() == 5) begin
      chk("rr_order0", grant_log[0], 0);
      chk("rr_order1", grant_log[1], 1);
      chk("rr_order2", grant_log[2], 2);
      chk("rr_order3", grant_log[3], 3);
      chk("rr_order4", grant_log[4], 0);
      chk("rr_data0", data_log[0], 1);
      chk("rr_data3", data_log[3], 4);
      chk("rr_data4", data_log[4], 15);
    end

    // backpressure on the response
    rsp_ready = 1'b0;
    set_req(1, rnd(), rnd(), 1);
    set_req(3, rnd(), rnd(), 1);
    for (int n = 0; n < 50 && !last_rv; n++) tick();
    chk("bp_rsp_seen", last_rv, 1);
    repeat (20) tick();
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("grant_after_bp", last_hs != 0, 1);
    run_until_idle(60);

    // stray done in IDLE and in ISSUE
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) tick();
    set_req(0, rnd(), rnd(), 1);
    wait_accept();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_in_issue", last_start, 1);
    run_until_idle(60);

    // reset four cycles into WAIT
    set_req(2, 255'h1234, 255'h5678, 1);
    wait_accept();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_mm_start", mm_start, 0);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_mm_a", mm_a, 0);
    chk("arst_mm_b", mm_b, 0);
    reset_model();
    grant_log.delete();
    set_req(3, rnd(), rnd(), 1);
    set_req(0, rnd(), rnd(), 1);
    repeat (2) tick();
    rst = 1'b0;
    run_until_idle(80);
    chk("post_rst_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("post_rst_first", grant_log[0], 0);
      chk("post_rst_second", grant_log[1], 3);
    end

`ifdef MM_TIMEOUT_EN
    core_en = 1'b0;
    to_mode = 1'b1;
    rsp_ready = 1'b0;
    set_req(1, rnd(), rnd(), 1);
    wait_accept();
    for (int n = 0; n < 60 && !last_rv; n++) tick();
    chk("to_rsp_seen", last_rv, 1);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (2) tick();
    rsp_ready = 1'b1;
    run_until_idle(20);
    to_mode = 1'b0;
    core_en = 1'b1;
`endif

    // random traffic against the reference
    rnd_mode = 1'b1;
    repeat (600) tick();
    rnd_mode = 1'b0;
    rsp_ready = 1'b1;
    run_until_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
